// File: rtl/interval_timer_arb.sv
// rtl/interval_timer_arb.sv - round-robin arbiter sequencing one shared interval counter
// Grants one requester at a time, counts 0..max_r, pulses done, then re-arbitrates.
module interval_timer_arb #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] max_val,
   input  logic                  abort,
   output logic [NREQ-1:0]       grant,
   output logic                  busy,
   output logic [WIDTH-1:0]      cnt,
   output logic [NREQ-1:0]       done
);

   localparam int PTR_W = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              busy_q, busy_d;
   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  max_q, max_d;
   logic [PTR_W-1:0]  last_q, last_d;
   logic [PTR_W-1:0]  owner_q, owner_d;

   logic [PTR_W-1:0]  win;
   logic              win_vld;
   logic              cancel;
   int                pick_idx;

   // First set request strictly after the last served requester, wrapping around.
   always_comb begin
      win      = '0;
      win_vld  = 1'b0;
      pick_idx = 0;
      for (int i = 1; i <= NREQ; i++) begin
         pick_idx = int'(last_q) + i;
         if (pick_idx >= NREQ) pick_idx = pick_idx - NREQ;
         if (!win_vld && req[pick_idx]) begin
            win_vld = 1'b1;
            win     = pick_idx[PTR_W-1:0];
         end
      end
   end

   assign cancel = abort || !req[owner_q];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      last_d  = last_q;
      owner_d = owner_q;
      done_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               state_d      = S_LOAD;
               grant_d      = '0;
               grant_d[win] = 1'b1;
               busy_d       = 1'b1;
               cnt_d        = '0;
               max_d        = max_val[int'(win)*WIDTH +: WIDTH];
               owner_d      = win;
            end
         end
         S_LOAD, S_RUN: begin
            // Cancellation wins over a completion in the same cycle; the owner still
            // becomes last_ptr so a cancelled requester does not jump the queue.
            if (cancel) begin
               state_d = S_IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
               last_d  = owner_q;
            end else if (state_q == S_LOAD) begin
               state_d = S_RUN;
            end else if (cnt_q == max_q) begin
               state_d          = S_DONE;
               done_d[owner_q]  = 1'b1;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            last_d  = owner_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         done_q  <= '0;
         max_q   <= '0;
         last_q  <= PTR_W'(NREQ - 1);
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         max_q   <= max_d;
         last_q  <= last_d;
         owner_q <= owner_d;
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;
   assign cnt   = cnt_q;
   assign done  = done_q;

endmodule

// File: tb/tb_interval_timer_arb.sv
// tb/tb_interval_timer_arb.sv - self-checking bench for interval_timer_arb
// Interval-level reference model: owner, edges since grant, latched terminal count.
module tb_interval_timer_arb;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] max_val;
   logic                  abort;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic [WIDTH-1:0]      cnt;
   logic [NREQ-1:0]       done;

   always #5 clk = ~clk;

   interval_timer_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .max_val (max_val),
      .abort   (abort),
      .grant   (grant),
      .busy    (busy),
      .cnt     (cnt),
      .done    (done)
   );

   int n_vec = 0;
   int n_mis = 0;

   int m_owner, m_k, m_M, m_last, m_cnt;
   logic [NREQ-1:0] g_prev = '0;
   logic [NREQ-1:0] gq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Interval timeline: grant at edge t (k=0), cnt=min(k-1,M) for k>=1, done at k=M+2,
   // released on the edge after done or when cancelled while k<=M+1.
   task automatic model_edge();
      if (!rst_n) begin
         m_owner = -1; m_last = NREQ - 1; m_cnt = 0; m_k = 0; m_M = 0;
      end else if (m_owner < 0) begin
         for (int i = 1; i <= NREQ; i++) begin
            int c;
            c = (m_last + i) % NREQ;
            if (m_owner < 0 && req[c]) m_owner = c;
         end
         if (m_owner >= 0) begin
            m_k = 0;
            m_M = int'(max_val[m_owner*WIDTH +: WIDTH]);
            m_cnt = 0;
         end
      end else if (m_k <= m_M + 1 && (abort || !req[m_owner])) begin
         m_last = m_owner; m_owner = -1;
      end else if (m_k == m_M + 2) begin
         m_last = m_owner; m_owner = -1;
      end else begin
         m_k++;
         m_cnt = (m_k <= 1) ? 0 : ((m_k - 1 < m_M) ? m_k - 1 : m_M);
      end
   endtask

   task automatic step();
      logic [NREQ-1:0] eg, ed;
      @(posedge clk);
      model_edge();
      #1;
      eg = '0;
      ed = '0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         if (m_k == m_M + 2) ed[m_owner] = 1'b1;
      end
      chk("grant", 32'(grant), 32'(eg));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("cnt", 32'(cnt), 32'(m_cnt));
      chk("done", 32'(done), 32'(ed));
      chk("done_sub_grant", 32'(done & ~grant), 32'(0));
      if (grant != 0 && grant != g_prev) gq.push_back(grant);
      g_prev = grant;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; abort = 1'b0; max_val = '0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic set_max(input int i, input int v);
      max_val[i*WIDTH +: WIDTH] = WIDTH'(v);
   endtask

   task automatic chk_gq(input string tag, input int idx, input logic [NREQ-1:0] exp);
      if (idx < gq.size()) chk(tag, 32'(gq[idx]), 32'(exp));
      else chk(tag, 32'hdead, 32'(exp));
   endtask

   initial begin
      int exp_c[4];
      logic [NREQ-1:0] order[5];
      int done_step;

      do_reset();
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));

      // single request, terminal count 3
      set_max(0, 3);
      req = 4'b0001;
      step();
      chk("tp1_grant", 32'(grant), 32'(4'b0001));
      exp_c = '{0, 1, 2, 3};
      for (int i = 0; i < 4; i++) begin
         step();
         chk("tp1_cnt", 32'(cnt), 32'(exp_c[i]));
      end
      step();
      chk("tp1_done", 32'(done), 32'(4'b0001));
      req = '0;
      step();
      chk("tp1_busy_low", 32'(busy), 32'(0));

      // all requesting with zero terminal counts: strict rotation
      do_reset();
      req = 4'hF;
      gq.delete();
      repeat (20) step();
      order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) chk_gq("tp2_order", i, order[i]);

      // last_ptr=1 with requesters 2 and 0 pending
      do_reset();
      req = 4'b0010;
      repeat (3) step();
      chk("tp3_done1", 32'(done), 32'(4'b0010));
      req = 4'b0101;
      gq.delete();
      repeat (12) step();
      chk_gq("tp3_first", 0, 4'b0100);
      chk_gq("tp3_second", 1, 4'b0001);

      // abort mid-run
      do_reset();
      set_max(0, 10);
      req = 4'b0001;
      for (int i = 0; i < 20 && !(m_owner == 0 && m_cnt == 5); i++) step();
      chk("tp4_reach", 32'(cnt), 32'(5));
      abort = 1'b1;
      step();
      chk("tp4_grant", 32'(grant), 32'(0));
      chk("tp4_nodone", 32'(done), 32'(0));
      abort = 1'b0;
      req = 4'b0011;
      gq.delete();
      repeat (4) step();
      chk_gq("tp4_next", 0, 4'b0010);

      // reset mid-run
      do_reset();
      set_max(0, 10);
      req = 4'b0001;
      for (int i = 0; i < 20 && !(m_owner == 0 && m_cnt == 7); i++) step();
      chk("tp5_reach", 32'(cnt), 32'(7));
      rst_n = 1'b0;
      step();
      chk("tp5_grant", 32'(grant), 32'(0));
      chk("tp5_cnt", 32'(cnt), 32'(0));
      chk("tp5_busy", 32'(busy), 32'(0));
      rst_n = 1'b1;
      req = 4'hF;
      gq.delete();
      repeat (3) step();
      chk_gq("tp5_prio", 0, 4'b0001);

      // full-range terminal count
      do_reset();
      set_max(0, 255);
      req = 4'b0001;
      done_step = -1;
      for (int i = 1; i <= 258; i++) begin
         step();
         if (done[0] && done_step < 0) done_step = i;
      end
      chk("tp6_done_edge", 32'(done_step), 32'(258));
      chk("tp6_cnt_top", 32'(cnt), 32'(255));
      req = '0;
      repeat (2) step();
      chk("tp6_cnt_hold", 32'(cnt), 32'(255));
      chk("tp6_idle", 32'(busy), 32'(0));

      // randomized traffic with aborts, dropped requests, changing terminal counts, resets
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
               if ($urandom_range(39) == 0) req[i] = 1'b0;
            end else if ($urandom_range(5) == 0) begin
               req[i] = 1'b1;
            end
            if ($urandom_range(3) == 0)
               set_max(i, ($urandom_range(9) == 0) ? int'($urandom_range(40)) : int'($urandom_range(6)));
         end
         abort = ($urandom_range(31) == 0);
         rst_n = ($urandom_range(499) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/interval_timer_arb.md
Name: interval_timer_arb

Overview:
- Shares one WIDTH-bit interval counter among NREQ requesters.
- Each requester raises req with its own terminal count. The block grants one requester at a time in round-robin order, runs the counter from 0 up to that terminal count, pulses that requester's done, then re-arbitrates.
- Sits between the channel engines and the shared timing resource; is the sole sequencer of that counter.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, counter and terminal-count width in bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  NREQ  per-requester request level; must hold until done or abort.
- max_val  input  NREQ*WIDTH  terminal counts, requester i at bits [i*WIDTH +: WIDTH].
- abort  input  1  cancels the current interval.
- grant  output  NREQ  one-hot owner of the counter; all-zero when idle.
- busy  output  1  high in LOAD, RUN and DONE.
- cnt  output  WIDTH  current counter value.
- done  output  NREQ  one-cycle completion pulse, one-hot.

Behaviour:
- All outputs registered. On any clk edge with rst_n=0, regardless of state:
  - state=IDLE, grant=0, busy=0, cnt=0, done=0, max_r=0.
  - last_ptr=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req bit is set, select winner w as the first set bit scanning last_ptr+1, last_ptr+2, ... modulo NREQ.
  - Next state LOAD; grant=onehot(w); max_r latches max_val slice w; cnt<=0.
  - Otherwise stay in IDLE with grant=0.
- LOAD: one cycle; next state RUN; cnt stays 0.
- RUN:
  - If cnt==max_r, go to DONE.
  - Otherwise cnt<=cnt+1.
  - RUN lasts exactly max_r+1 cycles.
  - cnt never wraps: it stops at max_r, and max_r can be at most 2^WIDTH-1.
- DONE:
  - done[w]=1 for exactly this cycle.
  - last_ptr<=w; next state IDLE.
  - grant clears on entry to IDLE; cnt holds its final value until the next LOAD.
- Timeline with req sampled in IDLE at edge t:
  - grant visible after edge t.
  - done visible after edge t+M+2, where M=max_r.
  - grant is high for M+3 cycles in total.
  - Minimum IDLE gap between grants: 1 cycle.
- max_val=0: LOAD, one RUN cycle (cnt=0 matches), then DONE.
- max_val slice changing after LOAD: ignored; max_r is already latched.
- Abort, in LOAD or RUN:
  - Trigger: abort=1, or req[w] deasserted.
  - Next state IDLE, grant=0, no done pulse, last_ptr<=w (fairness preserved).
  - abort in IDLE or DONE has no effect; a completion in DONE still pulses.
- Simultaneous requests: exactly one grant per round, in round-robin order. No requester waits more than NREQ-1 intervals.
- New or changed req bits during an active interval are not considered until the next IDLE cycle.
- grant and done are always zero or one-hot; done[i] implies grant[i] was high in the same cycle.

Test Plan:
- Reset then req=4'b0001, max_val[0]=3 -> grant=0001 after 1 edge; cnt goes 0,0,1,2,3; done[0] pulses 5 edges after req sample; busy low in the following cycle.
- req=4'b1111 held, all max_val=0 -> grants in order 0001,0010,0100,1000,0001, each 3 cycles long with 1 IDLE cycle between; done follows the same order.
- req[2] and req[0] set, last_ptr=1 -> requester 2 wins first; requester 0 is served next.
- abort=1 during RUN at cnt=5 (max 10) -> IDLE next cycle, grant=0, no done; next grant goes to the following requester in rotation.
- rst_n=0 for one edge mid-RUN (cnt=7) -> next cycle all outputs zero, state IDLE; requester 0 has priority again.
- WIDTH=8, max_val=255 -> cnt reaches 255 without wrap; done after 258 edges; cnt holds 255 in IDLE.
